// File: rtl/mlaccel_qpi_slave.sv
// QPI slave front end: synchronises and deglitches the host pins, turns nibble pairs into bytes
// for the command decoder and serialises decoder bytes back out during read phases.
module mlaccel_qpi_slave #(
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILT          = 1,
  parameter logic [7:0] UNDERRUN_BYTE = 8'hFF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       qpi_csb,
  input  logic       qpi_clk,
  input  logic [3:0] qpi_io_di,
  output logic [3:0] qpi_io_do,
  output logic       qpi_io_oe,
  output logic       xfer_active,
  output logic       rx_start,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       xfer_end,
  input  logic       tx_dir,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       proto_err
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

  localparam int CW = $clog2(FILT + 1) + 1;

  logic [SYNC_STAGES-1:0]      csb_sync, clk_sync, sync_ok;
  logic [SYNC_STAGES-1:0][3:0] io_sync;
  logic                        csb_s, clk_s, sync_flushed;
  logic [3:0]                  io_s;

  logic [CW-1:0] filt_cnt;
  logic          fclk, fclk_rise, fclk_fall;

  state_t state, state_nx;
  logic   entering, leaving, busy;

  logic       half, first, dir_q;
  logic [3:0] hi_nib;
  logic [7:0] tx_byte;

  // sync_ok marks when the reset values have flushed out, so WAIT_IDLE only trusts a real csb=1
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= '1;
      clk_sync <= '1;
      io_sync  <= '0;
      sync_ok  <= '0;
    end else begin
      csb_sync <= {csb_sync[SYNC_STAGES-2:0], qpi_csb};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], qpi_clk};
      io_sync  <= {io_sync[SYNC_STAGES-2:0], qpi_io_di};
      sync_ok  <= {sync_ok[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign csb_s        = csb_sync[SYNC_STAGES-1];
  assign clk_s        = clk_sync[SYNC_STAGES-1];
  assign io_s         = io_sync[SYNC_STAGES-1];
  assign sync_flushed = sync_ok[SYNC_STAGES-1];

  // A level change is accepted only after FILT+1 consecutive samples disagree with fclk.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fclk      <= 1'b1;
      filt_cnt  <= '0;
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
    end else begin
      fclk_rise <= 1'b0;
      fclk_fall <= 1'b0;
      if (clk_s == fclk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CW'(FILT)) begin
        fclk      <= clk_s;
        filt_cnt  <= '0;
        fclk_rise <= clk_s;
        fclk_fall <= !clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= WAIT_IDLE;
    else         state <= state_nx;
  end

  // NOTE: the next-state default is assigned first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_IDLE: if (sync_flushed && csb_s) state_nx = IDLE;
      IDLE:      if (!csb_s)                state_nx = ACTIVE;
      ACTIVE:    if (csb_s)                 state_nx = IDLE;
      default:                              state_nx = WAIT_IDLE;
    endcase
  end

  always_comb begin
    xfer_active = (state == ACTIVE);
    entering    = (state == IDLE) && !csb_s;
    leaving     = (state == ACTIVE) && csb_s;
    busy        = (state == ACTIVE) && !csb_s;
  end

  // csb rising takes priority over an fclk edge in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      half      <= 1'b0;
      first     <= 1'b0;
      dir_q     <= 1'b0;
      hi_nib    <= '0;
      tx_byte   <= '0;
      rx_valid  <= 1'b0;
      rx_start  <= 1'b0;
      rx_data   <= '0;
      xfer_end  <= 1'b0;
      proto_err <= 1'b0;
      tx_ready  <= 1'b0;
      qpi_io_do <= '0;
      qpi_io_oe <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_start  <= 1'b0;
      xfer_end  <= 1'b0;
      proto_err <= 1'b0;
      tx_ready  <= 1'b0;
      if (!tx_dir) qpi_io_oe <= 1'b0;

      if (entering) begin
        half  <= 1'b0;
        first <= 1'b1;
        dir_q <= 1'b0;
      end else if (leaving) begin
        xfer_end  <= 1'b1;
        proto_err <= half;
        half      <= 1'b0;
        qpi_io_oe <= 1'b0;
        qpi_io_do <= '0;
      end else if (busy && (fclk_rise || fclk_fall)) begin
        dir_q <= tx_dir;
        if ((tx_dir != dir_q) && half) begin
          proto_err <= 1'b1;
          half      <= 1'b0;
        end else if (fclk_rise) begin
          half <= !half;
          if (!tx_dir) begin
            if (!half) begin
              hi_nib <= io_s;
            end else begin
              rx_valid <= 1'b1;
              rx_data  <= {hi_nib, io_s};
              rx_start <= first;
              first    <= 1'b0;
            end
          end
        end else if (tx_dir) begin
          qpi_io_oe <= 1'b1;
          if (half) begin
            qpi_io_do <= tx_byte[3:0];
          end else if (tx_valid) begin
            tx_ready  <= 1'b1;
            tx_byte   <= tx_data;
            qpi_io_do <= tx_data[7:4];
          end else begin
            proto_err <= 1'b1;
            tx_byte   <= UNDERRUN_BYTE;
            qpi_io_do <= UNDERRUN_BYTE[7:4];
          end
        end
      end
    end
  end

endmodule

// File: doc/mlaccel_qpi_slave.md
Name: mlaccel_qpi_slave

Overview:
- QPI slave front end inside mlaccel_top, directly behind the qpi_csb/qpi_clk/qpi_io0..3 pins.
- Oversamples the host's QPI signals in the `clock` domain, deglitches qpi_clk and deserialises nibble pairs into bytes for the command decoder.
- In read phases it serialises decoder-supplied bytes back onto the bus.
- Contains no command semantics: the decoder decides direction via tx_dir.

Parameters:
SYNC_STAGES, 2, synchroniser depth on qpi_csb, qpi_clk and qpi_io_di.
FILT, 1, extra consecutive identical qpi_clk samples required before a level change is accepted.
UNDERRUN_BYTE, 8'hFF, byte driven when the decoder has no tx byte ready.

Ports:
clock  in  1  system clock; all logic on posedge.
resetn  in  1  asynchronous active-low reset.
qpi_csb  in  1  chip select, active low, asynchronous to clock.
qpi_clk  in  1  QPI clock, asynchronous, may carry glitches shorter than one clock period.
qpi_io_di  in  4  pad input nibble; io0 is bit 0.
qpi_io_do  out  4  pad output nibble.
qpi_io_oe  out  1  pad output enable.
xfer_active  out  1  a transaction is in progress.
rx_start  out  1  qualifies rx_valid: this is the first byte of the transaction (the command byte).
rx_valid  out  1  one-cycle strobe; rx_data holds a complete byte.
rx_data  out  8  received byte.
xfer_end  out  1  one-cycle strobe when a transaction ends.
tx_dir  in  1  decoder selects read phase (1 = slave drives the bus).
tx_data  in  8  next byte to send.
tx_valid  in  1  tx_data is available.
tx_ready  out  1  one-cycle strobe; tx_data has been consumed.
proto_err  out  1  one-cycle strobe on a protocol error.

Behaviour:
- Reset: all outputs 0, qpi_io_do=0, qpi_io_oe=0, half=0, state=WAIT_IDLE. Synchroniser flops reset to csb=1, clk=1.
- Filtering:
  - The filtered clock fclk changes only after SYNC_STAGES synchronisation plus FILT+1 consecutive equal samples.
  - A 1-clock-wide glitch never produces an edge when FILT>=1.
  - Host requirement: each qpi_clk phase lasts at least FILT+2 clock periods.
- States:
  - WAIT_IDLE: entered from reset. Ignores all activity until synced csb=1, then goes to IDLE. A reset in mid-transaction therefore discards the rest of that transaction.
  - IDLE: synced csb=0 -> ACTIVE with half=0, first=1 and xfer_active=1 on the next cycle.
  - ACTIVE: synced csb=1 -> IDLE.
    - On leaving: xfer_active=0, xfer_end pulses for 1 cycle, qpi_io_oe=0 in the same cycle, half=0.
    - If half=1 at that point, proto_err also pulses and the partial byte is discarded (no rx_valid).
- Receive, ACTIVE with tx_dir=0, on an fclk rising edge:
  - half=0: latch synced io as the high nibble, half=1.
  - half=1: the next cycle has rx_valid=1 with rx_data={high,low} and rx_start=first; then first=0, half=0.
- Transmit, ACTIVE with tx_dir=1:
  - qpi_io_oe=1 from the first fclk falling edge seen with tx_dir=1 until csb rises or tx_dir drops (registered, 1-cycle latency).
  - fclk falling edge with half=0:
    - if tx_valid: tx_ready pulses and the byte is latched;
    - else: UNDERRUN_BYTE is latched and proto_err pulses.
    - Drive latched[7:4] on the next cycle.
  - fclk falling edge with half=1: drive latched[3:0].
  - The half counter advances on fclk rising edges in both directions, so the host samples the high then the low nibble.
  - Falling edges with tx_dir=1 do not generate rx_valid.
  - The host drives data on qpi_clk negedge and samples on posedge.
  - Slave output settles within SYNC_STAGES+FILT+2 clocks after the qpi_clk falling edge.
- Simultaneous events:
  - csb rising wins over a same-cycle fclk edge; that edge is ignored.
  - tx_dir is sampled only at fclk edges.
  - A change of tx_dir with half=1 raises proto_err and forces half=0.
- The wait (dummy) byte is generated by the decoder: it asserts tx_dir and supplies tx_data as needed.
- Counters: only the single half bit; no wrap-around beyond it.

Test Plan:
- Write: csb low, send 0x21 then 0xA5, 0x3C, csb high:
  - rx_valid x3 with rx_data 0x21 (rx_start=1), 0xA5, 0x3C (rx_start=0);
  - xfer_end x1; proto_err never.
- Glitchy clock: same stream with a 1 ns low pulse inserted in each high phase (FILT=1) -> identical rx sequence, no extra bytes.
- Read: send 0x22, decoder sets tx_dir=1 offering 0x5A then 0x00:
  - the host samples nibbles 5,A,0,0;
  - tx_ready pulses twice; qpi_io_oe=1 only during the tx phase and 0 within 1 cycle of csb rising.
- Underrun: tx_dir=1 with tx_valid=0 -> host reads 0xFF, proto_err pulses once, tx_ready stays 0.
- Partial byte: send one nibble then raise csb -> no rx_valid; xfer_end and proto_err pulse together; the next transaction's first byte has rx_start=1.
- Reset mid-transfer: assert resetn=0 after 3 nibbles with csb held low, release, continue clocking -> no rx_valid until csb goes high and then low again. After that, 0x20 is received with rx_start=1.
